// File: rtl/snake_dir_queue.sv
// Snake direction front end: debounces five buttons, filters turns against the
// queue tail, and holds accepted turns in a small FIFO drained by game ticks.
module snake_dir_queue #(
  parameter int DEB_BITS      = 16,
  parameter int QDEPTH        = 4,
  parameter int ALLOW_REVERSE = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_pause,
  input  logic                     step,
  output logic [2:0]               dir,
  output logic                     U,
  output logic                     D,
  output logic                     L,
  output logic                     R,
  output logic                     noMove,
  output logic                     paused,
  output logic [$clog2(QDEPTH):0]  q_count,
  output logic                     overflow
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  // Button index: 0 up, 1 down, 2 left, 3 right, 4 pause.
  logic [4:0]          rawBtn;
  logic [4:0]          syncA;
  logic [4:0]          syncB;
  logic [4:0]          debState;
  logic [4:0]          pressEvt;
  logic [DEB_BITS-1:0] debCnt [5];

  logic [2:0]    qMem [QDEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] qCount;

  logic [2:0] cand;
  logic [2:0] oppCand;
  logic [2:0] tail;
  logic [2:0] headDir;
  logic       accept;
  logic       full;
  logic       doPop;
  logic       doPush;

  assign rawBtn  = {btn_pause, btn_right, btn_left, btn_down, btn_up};
  assign q_count = qCount;

  always_ff @(posedge clock) begin
    if (reset) begin
      syncA    <= '0;
      syncB    <= '0;
      debState <= '0;
      pressEvt <= '0;
      for (int i = 0; i < 5; i++) begin
        debCnt[i] <= '0;
      end
    end else begin
      syncA <= rawBtn;
      syncB <= syncA;
      for (int i = 0; i < 5; i++) begin
        pressEvt[i] <= 1'b0;
        if (syncB[i] == debState[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] == '1) begin
          debState[i] <= ~debState[i];
          debCnt[i]   <= '0;
          pressEvt[i] <= ~debState[i];
        end else begin
          debCnt[i] <= debCnt[i] + DEB_BITS'(1);
        end
      end
    end
  end

  // The tail is judged before any same-cycle pop, so a pop never unblocks a reversal.
  always_comb begin
    cand = DIR_NONE;
    if (pressEvt[0]) begin
      cand = DIR_UP;
    end else if (pressEvt[1]) begin
      cand = DIR_DOWN;
    end else if (pressEvt[2]) begin
      cand = DIR_LEFT;
    end else if (pressEvt[3]) begin
      cand = DIR_RIGHT;
    end

    case (cand)
      DIR_UP:    oppCand = DIR_DOWN;
      DIR_DOWN:  oppCand = DIR_UP;
      DIR_LEFT:  oppCand = DIR_RIGHT;
      DIR_RIGHT: oppCand = DIR_LEFT;
      default:   oppCand = DIR_NONE;
    endcase

    tail    = (qCount != '0) ? qMem[wrPtr - PW'(1)] : dir;
    headDir = qMem[rdPtr];
    full    = (qCount == FULL);
    doPop   = step && !paused && (qCount != '0);

    accept = (cand != DIR_NONE) && !paused && (cand != tail);
    if (ALLOW_REVERSE == 0 && tail != DIR_NONE && tail == oppCand) begin
      accept = 1'b0;
    end

    doPush = accept && (!full || doPop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      qCount <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qMem[i] <= DIR_NONE;
      end
    end else begin
      if (doPush) begin
        qMem[wrPtr] <= cand;
        wrPtr       <= wrPtr + PW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      if (doPush && !doPop) begin
        qCount <= qCount + CW'(1);
      end else if (doPop && !doPush) begin
        qCount <= qCount - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dir      <= DIR_NONE;
      U        <= 1'b0;
      D        <= 1'b0;
      L        <= 1'b0;
      R        <= 1'b0;
      noMove   <= 1'b1;
      paused   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= accept && full && !doPop;
      if (pressEvt[4]) begin
        paused <= ~paused;
      end
      if (doPop) begin
        dir    <= headDir;
        U      <= (headDir == DIR_UP);
        D      <= (headDir == DIR_DOWN);
        L      <= (headDir == DIR_LEFT);
        R      <= (headDir == DIR_RIGHT);
        noMove <= (headDir == DIR_NONE);
      end
    end
  end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Bench for snake_dir_queue: a queue-based reference model checked every cycle,
// plus directed button scenarios with literal expectations.
module tb_snake_dir_queue;

  localparam int DEB = 2;
  localparam int QD  = 4;
  localparam int WIN = 1 << DEB;

  localparam bit [4:0] B_UP    = 5'b00001;
  localparam bit [4:0] B_DOWN  = 5'b00010;
  localparam bit [4:0] B_LEFT  = 5'b00100;
  localparam bit [4:0] B_RIGHT = 5'b01000;
  localparam bit [4:0] B_PAUSE = 5'b10000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0, btnPause = 1'b0;
  logic       step = 1'b0;
  logic [2:0] dir;
  logic       U, D, L, R, noMove, paused, overflow;
  logic [2:0] qCount;

  int total = 0;
  int bad = 0;
  int ovfPulses = 0;
  int ovfBase;

  snake_dir_queue #(.DEB_BITS(DEB), .QDEPTH(QD), .ALLOW_REVERSE(0)) dut (
    .clock(clock), .reset(reset),
    .btn_up(btnUp), .btn_down(btnDown), .btn_left(btnLeft), .btn_right(btnRight),
    .btn_pause(btnPause), .step(step),
    .dir(dir), .U(U), .D(D), .L(L), .R(R), .noMove(noMove), .paused(paused),
    .q_count(qCount), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: debounce as "the raw line, seen two clocks late, has
  // disagreed with the debounced level for a whole window", and a plain queue.
  bit [15:0] hist [5];
  bit [4:0]  mDeb;
  bit [4:0]  evPend;
  int        mq[$];
  int        mDir = 0;
  bit        mPaused = 0;
  bit        mOvf = 0;
  bit        modelValid = 0;

  always @(posedge clock) begin
    bit [4:0] raw;
    bit [4:0] evNext;
    int cand;
    int tail;
    bit rev;
    bit acc;
    bit popNow;
    bit stable;
    raw = {btnPause, btnRight, btnLeft, btnDown, btnUp};
    if (reset) begin
      for (int b = 0; b < 5; b++) hist[b] = '0;
      mDeb = '0;
      evPend = '0;
      mq.delete();
      mDir = 0;
      mPaused = 0;
      mOvf = 0;
      modelValid = 1;
    end else begin
      for (int b = 0; b < 5; b++) hist[b] = {hist[b][14:0], raw[b]};
      cand = 0;
      if (!mPaused) begin
        if (evPend[0]) cand = 1;
        else if (evPend[1]) cand = 2;
        else if (evPend[2]) cand = 3;
        else if (evPend[3]) cand = 4;
      end
      tail = (mq.size() > 0) ? mq[$] : mDir;
      rev = (tail != 0) && (((cand + 1) / 2) == ((tail + 1) / 2));
      acc = (cand != 0) && (cand != tail) && !rev;
      popNow = step && !mPaused && (mq.size() > 0);
      mOvf = 0;
      if (popNow) mDir = mq.pop_front();
      if (acc) begin
        if (mq.size() < QD) mq.push_back(cand);
        else mOvf = 1;
      end
      if (evPend[4]) mPaused = !mPaused;
      evNext = '0;
      for (int b = 0; b < 5; b++) begin
        stable = 1;
        for (int j = 0; j < WIN; j++) begin
          if (hist[b][2 + j] == mDeb[b]) stable = 0;
        end
        if (stable) begin
          mDeb[b] = ~mDeb[b];
          if (mDeb[b]) evNext[b] = 1;
        end
      end
      evPend = evNext;
    end
  end

  always @(negedge clock) begin
    if (modelValid) begin
      checkOutput("dir", dir, mDir);
      checkOutput("U", U, mDir == 1);
      checkOutput("D", D, mDir == 2);
      checkOutput("L", L, mDir == 3);
      checkOutput("R", R, mDir == 4);
      checkOutput("noMove", noMove, mDir == 0);
      checkOutput("paused", paused, mPaused);
      checkOutput("q_count", qCount, mq.size());
      checkOutput("overflow", overflow, mOvf);
      if (overflow) ovfPulses++;
    end
  end

  task automatic setButtons(input bit [4:0] mask);
    {btnPause, btnRight, btnLeft, btnDown, btnUp} = mask;
  endtask

  // Hold the buttons 8 clocks, optionally raise step on clock stepAt, then release and settle.
  task automatic applyStimulus(input bit [4:0] mask, input int stepAt);
    @(negedge clock);
    setButtons(mask);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      step = (i == stepAt);
    end
    step = 1'b0;
    setButtons(5'b0);
    repeat (8) @(negedge clock);
  endtask

  task automatic pulseStep();
    @(negedge clock);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checkOutput("rst dir", dir, 0);
    checkOutput("rst noMove", noMove, 1);
    checkOutput("rst UDLR", {U, D, L, R}, 0);
    checkOutput("rst q_count", qCount, 0);
    checkOutput("rst paused", paused, 0);

    applyStimulus(B_RIGHT, 0);
    checkOutput("right queued", qCount, 1);
    pulseStep();
    checkOutput("right dir", dir, 4);
    checkOutput("right R", R, 1);
    checkOutput("right noMove", noMove, 0);
    checkOutput("right drained", qCount, 0);

    ovfBase = ovfPulses;
    applyStimulus(B_LEFT, 0);
    checkOutput("reverse rejected", qCount, 0);
    checkOutput("reverse no ovf", ovfPulses, ovfBase);
    applyStimulus(B_UP, 0);
    pulseStep();
    checkOutput("up U", U, 1);
    checkOutput("up dir", dir, 1);

    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      btnUp = ~btnUp;
    end
    btnUp = 1'b0;
    repeat (8) @(negedge clock);
    checkOutput("bounce ignored", qCount, 0);

    applyStimulus(B_RIGHT, 0);
    pulseStep();
    checkOutput("back right", dir, 4);
    applyStimulus(B_UP, 0);
    applyStimulus(B_LEFT, 0);
    applyStimulus(B_DOWN, 0);
    applyStimulus(B_RIGHT, 0);
    checkOutput("queue full", qCount, 4);
    ovfBase = ovfPulses;
    applyStimulus(B_UP, 0);
    checkOutput("one ovf pulse", ovfPulses, ovfBase + 1);
    checkOutput("full kept", qCount, 4);
    pulseStep(); checkOutput("pop1", dir, 1);
    pulseStep(); checkOutput("pop2", dir, 3);
    pulseStep(); checkOutput("pop3", dir, 2);
    pulseStep(); checkOutput("pop4", dir, 4);

    applyStimulus(B_UP, 0);
    applyStimulus(B_PAUSE, 0);
    checkOutput("paused on", paused, 1);
    applyStimulus(B_LEFT, 0);
    checkOutput("paused press dropped", qCount, 1);
    pulseStep();
    checkOutput("paused step dir", dir, 4);
    checkOutput("paused keeps queue", qCount, 1);
    applyStimulus(B_PAUSE, 0);
    checkOutput("paused off", paused, 0);
    pulseStep();
    checkOutput("unpaused pop", dir, 1);
    checkOutput("unpaused empty", qCount, 0);

    applyStimulus(B_LEFT, 0);
    applyStimulus(B_DOWN, 0);
    applyStimulus(B_RIGHT, 0);
    applyStimulus(B_UP, 0);
    ovfBase = ovfPulses;
    applyStimulus(B_LEFT, 6);
    checkOutput("push+pop count", qCount, 4);
    checkOutput("push+pop dir", dir, 3);
    checkOutput("push+pop no ovf", ovfPulses, ovfBase);
    pulseStep(); checkOutput("drain1", dir, 2);
    pulseStep(); checkOutput("drain2", dir, 4);
    pulseStep(); checkOutput("drain3", dir, 1);
    pulseStep(); checkOutput("drain4", dir, 3);

    applyStimulus(B_UP, 6);
    checkOutput("no bypass dir", dir, 3);
    checkOutput("no bypass count", qCount, 1);
    pulseStep();
    checkOutput("late pop", dir, 1);

    applyStimulus(B_DOWN | B_LEFT, 0);
    checkOutput("priority reject", qCount, 0);
    applyStimulus(B_RIGHT | B_LEFT, 0);
    pulseStep();
    checkOutput("priority left", dir, 3);

    @(negedge clock);
    btnDown = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checkOutput("midrst dir", dir, 0);
    checkOutput("midrst count", qCount, 0);
    repeat (6) @(negedge clock);
    checkOutput("held early", qCount, 0);
    @(negedge clock);
    checkOutput("held press", qCount, 1);
    btnDown = 1'b0;
    repeat (10) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
